cpu_clk_ctrl: RTL
=================

Name: cpu_clk_ctrl

Overview:
Run/step/halt controller for the CPU core. It generates a single-cycle clock enable, `cpu_tick`, in one of three ways:
- periodically, from a programmable divisor (RUN);
- once per debounced push-button press (STEP);
- never (HALT).
It sits between the board clock and the CPU datapath and replaces the free-running divided clock with a clock enable. All CPU registers stay on `clk`.

Parameters:
CNT_W, 32, width of divisor register and period counter
DEFAULT_DIV, 100_000_000, divisor after reset (1 tick/s at 100 MHz)
DB_CYCLES, 1_000_000, consecutive stable cycles required to accept a button level change

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
mode  input  2  00 HALT, 01 RUN, 10 STEP, 11 treated as HALT
step_btn  input  1  raw asynchronous push button, active-high
div_load  input  1  one-cycle strobe: load div_value into divisor register
div_value  input  CNT_W  new divisor (ticks period in clk cycles)
halt_req  input  1  from CPU HLT decode; forces halt while in RUN
cpu_tick  output  1  one-cycle clock enable to CPU
running  output  1  high while in RUN state and ticking
halted  output  1  high when halt_req latched
tick_count  output  16  number of ticks issued, wraps 0xFFFF->0x0000

Behaviour:
- Reset (rst=1 at rising clk) sets:
  - state=S_HALT, cpu_tick=0, running=0, halted=0, tick_count=0;
  - divisor=DEFAULT_DIV, period counter=0;
  - debouncer state=0 (level 0, stable count 0).
- Divisor register:
  - div_load=1 writes div_value; a value of 0 is stored as 1.
  - A load also clears the period counter in the same cycle.
- Period counter:
  - Counts 0..divisor-1 in S_RUN only; cleared in every other state.
  - The tick fires on the cycle the counter equals divisor-1, and the counter wraps to 0.
  - The first tick comes exactly `divisor` cycles after entry to S_RUN. Divisor=1 gives a tick every cycle.
- Button path:
  - 2-FF synchronizer, then debouncer.
  - The debounced level changes only after the synchronized input differs from it for DB_CYCLES consecutive cycles; any bounce restarts the count.
  - A press is a 0->1 transition of the debounced level.
- States:
  - S_HALT: cpu_tick=0. Go to S_RUN when mode=01 and halted=0. Go to S_STEP when mode=10.
  - S_RUN: running=1; ticks as above. Leaves to S_HALT on mode!=01 or halt_req=1; a tick is not issued in the exit cycle.
  - S_STEP: each press issues exactly one cpu_tick, one cycle after the debounced rising edge. Presses in other modes are discarded, not queued. Go to S_RUN on mode=01 (if halted=0); go to S_HALT on mode=00/11.
- halted flag:
  - Set by halt_req=1 in S_RUN; cleared only when mode=00.
  - While set, S_RUN cannot be entered. STEP remains allowed, for debugging past HLT.
- tick_count increments by 1 on every cycle with cpu_tick=1.
- Simultaneous events:
  - halt_req and a due tick in the same cycle: halt wins, no tick.
  - div_load and a due tick in the same cycle: load wins, no tick, counter restarts.
- rst in mid-operation aborts any in-flight debounce, pending step or burst.

Optional Feature:
Macro STEP_BURST_EN.
- Defined: adds input `burst_len` (8 bits).
  - In S_STEP each press issues burst_len ticks (0 treated as 1), spaced `divisor` cycles apart, with the first tick one cycle after the press.
  - Presses arriving during a burst are ignored.
  - A mode change aborts the remaining burst.
- Undefined: port absent; exactly one tick per press.

Test Plan:
- Reset: rst high 2 cycles, then low, mode=00 -> cpu_tick=0, tick_count=0, running=0 for 100 cycles.
- Run period: div_load with div_value=5, mode=01 -> ticks at cycles 5,10,15 after entry; after 20 cycles tick_count=4. Repeat with div_value=0 -> tick every cycle.
- Step/debounce (DB_CYCLES=4): mode=10, button bounces 1-0-1 in 3 cycles then holds high 10 cycles -> exactly one cpu_tick, 1 cycle after the debounced edge. Press with mode=00 -> no tick.
- HLT: mode=01, divisor=3, halt_req pulsed on a tick-due cycle -> no tick that cycle; halted=1; running=0. Keep mode=01 -> no ticks. Set mode=00 then 01 -> ticking resumes, first tick 3 cycles later.
- Reload in RUN: divisor=10, div_load value 4 at counter=7 -> next tick exactly 4 cycles after the load.
- Burst (STEP_BURST_EN, divisor=2, burst_len=3): one press -> ticks at +1, +3, +5; a second press mid-burst is ignored; tick_count=3.

Source files
------------

// File: rtl/cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clk_ctrl
// Purpose  : Run/step/halt clock-enable generator for the CPU core.
//            Optional macro STEP_BURST_EN adds burst stepping (burst_len port).
// Revision : 1.0
// ============================================================================
module cpu_clk_ctrl #(
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 100_000_000,
    parameter int DB_CYCLES   = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             step_btn,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_value,
    input  logic             halt_req,
`ifdef STEP_BURST_EN
    input  logic [7:0]       burst_len,
`endif
    output logic             cpu_tick,
    output logic             running,
    output logic             halted,
    output logic [15:0]      tick_count
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] DIV_RST = (DEFAULT_DIV == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_DIV);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             sync1, sync2, db_level, db_prev;
    logic [DB_W-1:0]  db_cnt;
    logic [CNT_W-1:0] divisor, div_m1, period_cnt, step_gap;
    logic [7:0]       step_rem, step_len;
    logic             press, run_tick, step_ok, step_tick;

    // Button: two-flop synchronizer, then a level debouncer that restarts on any bounce
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1   <= step_btn;
            sync2   <= sync1;
            db_prev <= db_level;
            if (sync2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = db_level & ~db_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            divisor <= DIV_RST;
        end else if (div_load) begin
            divisor <= (div_value == '0) ? CNT_W'(1) : div_value;
        end
    end

    assign div_m1 = divisor - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (state != S_RUN || div_load || period_cnt == div_m1) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // Halt request and a divisor reload both take priority over a due tick
    assign run_tick = (state == S_RUN) && (mode == 2'b01) && !halt_req &&
                      !div_load && (period_cnt == div_m1);

`ifdef STEP_BURST_EN
    assign step_len = (burst_len == 8'd0) ? 8'd1 : burst_len;
`else
    assign step_len = 8'd1;
`endif

    // Step sequencer: a press loads the tick budget; first tick lands the next cycle
    assign step_ok   = (state == S_STEP) && (mode == 2'b10);
    assign step_tick = step_ok && (step_rem != 8'd0) && (step_gap == '0);

    always_ff @(posedge clk) begin
        if (rst || !step_ok) begin
            step_rem <= 8'd0;
            step_gap <= '0;
        end else if (step_rem == 8'd0) begin
            if (press) begin
                step_rem <= step_len;
                step_gap <= '0;
            end
        end else if (step_gap == '0) begin
            step_rem <= step_rem - 8'd1;
            step_gap <= div_m1;
        end else begin
            step_gap <= step_gap - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_HALT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HALT: begin
                if (mode == 2'b01 && !halted) begin
                    state_nxt = S_RUN;
                end else if (mode == 2'b10) begin
                    state_nxt = S_STEP;
                end
            end
            S_RUN: begin
                if (mode != 2'b01 || halt_req) begin
                    state_nxt = S_HALT;
                end
            end
            S_STEP: begin
                if (mode == 2'b01 && !halted) begin
                    state_nxt = S_RUN;
                end else if (mode == 2'b00 || mode == 2'b11) begin
                    state_nxt = S_HALT;
                end
            end
            default: state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (state == S_RUN && halt_req) begin
            halted <= 1'b1;
        end else if (mode == 2'b00) begin
            halted <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_count <= 16'd0;
        end else if (cpu_tick) begin
            tick_count <= tick_count + 16'd1;
        end
    end

    assign cpu_tick = run_tick | step_tick;
    assign running  = (state == S_RUN);

endmodule
`default_nettype wire
